// File: rtl/subleq_core.sv
// -----------------------------------------------------------------------------
// subleq_core
//   SUBLEQ sequencer acting as the initiator of a dual-port RAM with two
//   registered-address read ports (1-cycle latency) and one write port.
//   Each instruction (A, B, C) takes four cycles:
//     mem[B] <= mem[B] - mem[A]; if result <= 0 then PC <= C else PC <= PC + 3.
//   A taken branch to HALT_ADDR parks the core in a terminal halt state.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   HALT_ADDR  taken-branch target that halts the core
//
// Ports
//   CLK     in   1  system clock, all state on posedge
//   RST     in   1  synchronous, active-high reset
//   RUN     in   1  lets the next instruction start (sampled in S_FETCH_AB only)
//   STEP    in   1  single-step request (present only with SUBLEQ_STEP_EN)
//   dataA   in   8  RAM port A read data (one cycle after addrA)
//   dataB   in   8  RAM port B read data (one cycle after addrB)
//   addrA   out  8  RAM read port A address
//   addrB   out  8  RAM read port B address
//   addrC   out  8  RAM write address
//   dataC   out  8  RAM write data
//   WE      out  1  RAM write strobe
//   PC      out  8  current program counter
//   HALTED  out  1  high once the core has halted
//
// Configuration
//   SUBLEQ_STEP_EN  when defined, adds STEP: a rising edge arms exactly one
//                   instruction even with RUN low.
// -----------------------------------------------------------------------------
module subleq_core #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] HALT_ADDR = 8'hFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
`ifdef SUBLEQ_STEP_EN
  input  logic       STEP,
`endif
  input  logic [7:0] dataA,
  input  logic [7:0] dataB,
  output logic [7:0] addrA,
  output logic [7:0] addrB,
  output logic [7:0] addrC,
  output logic [7:0] dataC,
  output logic       WE,
  output logic [7:0] PC,
  output logic       HALTED
);

  typedef enum logic [2:0] {
    S_FETCH_AB,
    S_FETCH_C,
    S_OPER,
    S_EXEC,
    S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] r_ptr_a;
  logic [7:0] r_ptr_b;
  logic [7:0] r_ptr_c;

  logic [7:0] w_res;
  logic       w_le;
  logic       w_go;
  logic       w_advance;

  // In S_EXEC the RAM returns mem[ptrA] on port A and mem[ptrB] on port B.
  assign w_res = dataB - dataA;
  // Wrapping subtraction: bit 7 alone decides the sign, so 0x80-0x01=0x7F
  // is treated as positive.
  assign w_le  = w_res[7] | (w_res == 8'h00);

`ifdef SUBLEQ_STEP_EN
  logic r_step_q;
  logic r_armed;
  logic w_step_rise;

  assign w_step_rise = STEP & ~r_step_q;
  assign w_go        = RUN | r_armed;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_step_q <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_step_q <= STEP;
      // Consuming the arm takes priority; a held STEP produces no new edge.
      if (w_advance)        r_armed <= 1'b0;
      else if (w_step_rise) r_armed <= 1'b1;
    end
  end
`else
  assign w_go = RUN;
`endif

  assign w_advance = (r_state == S_FETCH_AB) && w_go;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH_AB;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH_AB: if (w_go) w_state_nxt = S_FETCH_C;
      S_FETCH_C:            w_state_nxt = S_OPER;
      S_OPER:               w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_le && (r_ptr_c == HALT_ADDR)) w_state_nxt = S_HALT;
        else                                w_state_nxt = S_FETCH_AB;
      end
      S_HALT:               w_state_nxt = S_HALT;
      default:              w_state_nxt = S_FETCH_AB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: PC and operand pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc    <= RESET_PC;
      r_ptr_a <= 8'h00;
      r_ptr_b <= 8'h00;
      r_ptr_c <= 8'h00;
    end else begin
      unique case (r_state)
        S_FETCH_C: begin
          r_ptr_a <= dataA;
          r_ptr_b <= dataB;
        end
        S_OPER: r_ptr_c <= dataA;
        // A halting branch loads ptrC, which equals HALT_ADDR by definition.
        S_EXEC: r_pc <= w_le ? r_ptr_c : (r_pc + 8'd3);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    addrA = r_pc;
    addrB = r_pc + 8'd1;
    addrC = 8'h00;
    dataC = 8'h00;
    WE    = 1'b0;
    unique case (r_state)
      S_FETCH_AB: ;
      S_FETCH_C:  addrA = r_pc + 8'd2;
      S_OPER: begin
        addrA = r_ptr_a;
        addrB = r_ptr_b;
      end
      S_EXEC: begin
        addrA = r_ptr_a;
        addrB = r_ptr_b;
        addrC = r_ptr_b;
        dataC = w_res;
        // Reset during execute must suppress the write landing on this edge.
        WE    = ~RST;
      end
      S_HALT: ;
      default: ;
    endcase
  end

  assign PC     = r_pc;
  assign HALTED = (r_state == S_HALT);

endmodule
